// File: rtl/bus_watchdog_ex_pkg.sv
// Shared definitions for the bus access watchdog: FSM state encoding and the
// default timeout limits used by bus masters and slaves on the system bus.
package bus_watchdog_ex_pkg;

   typedef enum logic [1:0] {
      STATE_IDLE      = 2'd0,
      STATE_COUNTING  = 2'd1,
      STATE_NOTIFYING = 2'd2
   } state_t;

   localparam int DEF_RD_TIMEOUT = 1000;
   localparam int DEF_WR_TIMEOUT = 1000;

endpackage

// File: rtl/bus_watchdog_ex_if.sv
// Shared system bus strobes and address; the master drives them and the
// watchdog observes them through the slave modport.
interface bus_watchdog_ex_if #(
   parameter int ADDR_WIDTH = 32
) ();

   logic                  rd_bus;
   logic                  wr_bus;
   logic [ADDR_WIDTH-1:0] addr_bus;

   modport master (output rd_bus, wr_bus, addr_bus);
   modport slave  (input  rd_bus, wr_bus, addr_bus);

endinterface

// File: rtl/bus_watchdog_ex_wd_counter.sv
// Access cycle counter: clears, increments up to a limit without wrapping, and
// flags when the count has reached that limit.
module wd_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clear,
   input  logic                 i_incr,
   input  logic [CNT_WIDTH-1:0] i_limit,
   output logic                 o_expired
);

   logic [CNT_WIDTH-1:0] r_count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_incr && (r_count != i_limit)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = (r_count == i_limit);

endmodule

// File: rtl/bus_watchdog_ex.sv
// Bus access watchdog: times each read/write access, forces completion on
// fc_bus when it overruns, and records the fault for software.
module bus_watchdog_ex
   import bus_watchdog_ex_pkg::*;
#(
   parameter int ADDR_WIDTH    = 32,
   parameter int CNT_WIDTH     = 16,
   parameter int RD_TIMEOUT    = DEF_RD_TIMEOUT,
   parameter int WR_TIMEOUT    = DEF_WR_TIMEOUT,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   bus_watchdog_ex_if.slave         bus,
   inout  wire                      fc_bus,
   input  logic                     enable,
   input  logic                     irq_clr,
   output logic                     access_timeout,
   output logic                     irq,
   output logic [ADDR_WIDTH-1:0]    fault_addr,
   output logic                     fault_is_wr,
   output logic [ERR_CNT_WIDTH-1:0] fault_count
);

   localparam logic [CNT_WIDTH-1:0] RD_LIMIT = CNT_WIDTH'(RD_TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] WR_LIMIT = CNT_WIDTH'(WR_TIMEOUT);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [ADDR_WIDTH-1:0]    r_addr;
   logic                     r_is_wr;
   logic [ADDR_WIDTH-1:0]    r_fault_addr;
   logic                     r_fault_is_wr;
   logic [ERR_CNT_WIDTH-1:0] r_fault_count;
   logic                     r_irq;

   logic                     w_strobe;
   logic                     w_fc_in;
   logic                     w_start;
   logic                     w_timeout;
   logic                     w_cnt_clr;
   logic                     w_cnt_inc;
   logic                     w_expired;
   logic [CNT_WIDTH-1:0]     w_limit;

   assign w_strobe = bus.rd_bus | bus.wr_bus;
   assign w_fc_in  = (fc_bus == 1'b1);
   assign w_limit  = r_is_wr ? WR_LIMIT : RD_LIMIT;

   wd_counter #(.CNT_WIDTH(CNT_WIDTH)) u_counter (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_cnt_clr),
      .i_incr   (w_cnt_inc),
      .i_limit  (w_limit),
      .o_expired(w_expired)
   );

   // NOTE: every signal driven here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_timeout   = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      case (r_state)
         STATE_IDLE: begin
            w_cnt_clr = 1'b1;
            if (enable && w_strobe) begin
               w_start     = 1'b1;
               w_state_nxt = STATE_COUNTING;
            end
         end
         STATE_COUNTING: begin
            // Slave completion outranks expiry in the same cycle.
            if (w_fc_in || !enable || !w_strobe) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = STATE_IDLE;
            end else if (w_expired) begin
               w_timeout   = 1'b1;
               w_state_nxt = STATE_NOTIFYING;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         STATE_NOTIFYING: begin
            // Our own fc_bus drive is ignored; only the master's release ends it.
            if (!w_strobe) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = STATE_IDLE;
            end
         end
         default: begin
            w_cnt_clr   = 1'b1;
            w_state_nxt = STATE_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= STATE_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr        <= '0;
         r_is_wr       <= 1'b0;
         r_fault_addr  <= '0;
         r_fault_is_wr <= 1'b0;
         r_fault_count <= '0;
         r_irq         <= 1'b0;
      end else begin
         if (w_start) begin
            r_addr  <= bus.addr_bus;
            r_is_wr <= bus.wr_bus;
         end
         if (w_timeout) begin
            r_fault_addr  <= r_addr;
            r_fault_is_wr <= r_is_wr;
            if (r_fault_count != '1) begin
               r_fault_count <= r_fault_count + 1'b1;
            end
         end
         // A new timeout wins over a simultaneous clear request.
         if (w_timeout) begin
            r_irq <= 1'b1;
         end else if (irq_clr) begin
            r_irq <= 1'b0;
         end
      end
   end

   assign access_timeout = (r_state == STATE_NOTIFYING);
   assign fc_bus         = access_timeout ? 1'b1 : 1'bz;
   assign irq            = r_irq;
   assign fault_addr     = r_fault_addr;
   assign fault_is_wr    = r_fault_is_wr;
   assign fault_count    = r_fault_count;

endmodule

// File: tb/tb_bus_watchdog_ex.sv
// Directed bench for bus_watchdog_ex: each access pushes its predicted outcome
// to a scoreboard queue, which is popped when the access resolves on the bus.
module tb_bus_watchdog_ex;

   localparam int AW    = 32;
   localparam int CW    = 8;
   localparam int RD_TO = 4;
   localparam int WR_TO = 2;
   localparam int EW    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          irq_clr;
   logic          slave_fc;
   logic          access_timeout;
   logic          irq;
   logic [AW-1:0] fault_addr;
   logic          fault_is_wr;
   logic [EW-1:0] fault_count;
   wire           fc_bus;

   // Released fc_bus reads back as 0 through the pull-down.
   pulldown (fc_bus);
   assign fc_bus = slave_fc ? 1'b1 : 1'bz;

   always #5 clk = ~clk;

   bus_watchdog_ex_if #(.ADDR_WIDTH(AW)) bus ();

   bus_watchdog_ex #(
      .ADDR_WIDTH   (AW),
      .CNT_WIDTH    (CW),
      .RD_TIMEOUT   (RD_TO),
      .WR_TIMEOUT   (WR_TO),
      .ERR_CNT_WIDTH(EW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .fc_bus        (fc_bus),
      .enable        (enable),
      .irq_clr       (irq_clr),
      .access_timeout(access_timeout),
      .irq           (irq),
      .fault_addr    (fault_addr),
      .fault_is_wr   (fault_is_wr),
      .fault_count   (fault_count)
   );

   typedef struct {
      bit          to;
      int          edges;
      logic [31:0] addr;
      bit          wr;
      logic [31:0] cnt;
   } exp_t;

   exp_t        q_exp[$];
   int          n_cmp   = 0;
   int          n_fail  = 0;
   logic [31:0] m_cnt   = 0;
   bit          m_irq   = 1'b0;
   logic [31:0] m_faddr = 0;
   bit          m_fwr   = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one access; *_at are cycle indices after the strobe is driven (0 = unused).
   task automatic run_access(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                             input int fc_at, input int drop_at, input int dis_at, input int clr_at);
      exp_t e;
      exp_t got;
      int   lim;
      int   k;
      int   seen_edges;
      bit   saw;
      lim = wr ? WR_TO : RD_TO;
      k = 0;
      if (fc_at > 0) k = fc_at;
      if (drop_at > 0 && (k == 0 || drop_at < k)) k = drop_at;
      if (dis_at > 0 && (k == 0 || dis_at < k)) k = dis_at;
      e.to    = (k == 0) || (k > lim + 1);
      e.edges = lim + 1;
      e.addr  = addr;
      e.wr    = wr;
      if (e.to) begin
         if (m_cnt != (1 << EW) - 1) m_cnt = m_cnt + 1;
         m_irq   = 1'b1;
         m_faddr = addr;
         m_fwr   = wr;
      end
      e.cnt = m_cnt;
      q_exp.push_back(e);

      bus.rd_bus   = rd;
      bus.wr_bus   = wr;
      bus.addr_bus = addr;
      saw = 1'b0;
      seen_edges = 0;
      for (int j = 1; j <= 30; j++) begin
         @(negedge clk);
         irq_clr = (j == clr_at);
         if (access_timeout) begin
            saw = 1'b1;
            seen_edges = j - 1;
            break;
         end
         if (j == fc_at) slave_fc = 1'b1;
         if (fc_at > 0 && j == fc_at + 1) begin
            slave_fc = 1'b0;
            bus.rd_bus = 1'b0;
            bus.wr_bus = 1'b0;
         end
         if (j == drop_at) begin
            bus.rd_bus = 1'b0;
            bus.wr_bus = 1'b0;
         end
         if (j == dis_at) enable = 1'b0;
         if (dis_at > 0 && j == dis_at + 10) begin
            bus.rd_bus = 1'b0;
            bus.wr_bus = 1'b0;
         end
         if (dis_at > 0 && j == dis_at + 11) enable = 1'b1;
      end

      got = q_exp.pop_front();
      check({tag, ".timeout"}, 32'(saw), 32'(got.to));
      if (got.to) begin
         check({tag, ".edges"}, 32'(seen_edges), 32'(got.edges));
         check({tag, ".fc_bus"}, 32'(fc_bus), 32'd1);
         check({tag, ".fault_addr"}, fault_addr, got.addr);
         check({tag, ".fault_is_wr"}, 32'(fault_is_wr), 32'(got.wr));
         check({tag, ".fault_count"}, 32'(fault_count), got.cnt);
         check({tag, ".irq"}, 32'(irq), 32'(m_irq));
         enable = 1'b0;
         @(negedge clk);
         check({tag, ".hold_no_enable"}, 32'(access_timeout), 32'd1);
         bus.rd_bus = 1'b0;
         bus.wr_bus = 1'b0;
         enable = 1'b1;
         @(negedge clk);
         check({tag, ".release_to"}, 32'(access_timeout), 32'd0);
         check({tag, ".release_fc"}, 32'(fc_bus), 32'd0);
      end else begin
         check({tag, ".fault_count"}, 32'(fault_count), got.cnt);
         check({tag, ".irq"}, 32'(irq), 32'(m_irq));
         check({tag, ".fault_addr"}, fault_addr, m_faddr);
         bus.rd_bus = 1'b0;
         bus.wr_bus = 1'b0;
         slave_fc = 1'b0;
         enable = 1'b1;
         @(negedge clk);
      end
      irq_clr = 1'b0;
   endtask

   task automatic pulse_clr(input string tag);
      @(negedge clk);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      m_irq = 1'b0;
      check(tag, 32'(irq), 32'(m_irq));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      bit saw;
      rst          = 1'b1;
      enable       = 1'b0;
      irq_clr      = 1'b0;
      slave_fc     = 1'b0;
      bus.rd_bus   = 1'b0;
      bus.wr_bus   = 1'b0;
      bus.addr_bus = '0;
      #1 rst = 1'b0;
      #1;
      check("rst.access_timeout", 32'(access_timeout), 32'd0);
      check("rst.irq", 32'(irq), 32'd0);
      check("rst.fault_addr", fault_addr, 32'd0);
      check("rst.fault_is_wr", 32'(fault_is_wr), 32'd0);
      check("rst.fault_count", 32'(fault_count), 32'd0);
      check("rst.fc_bus", 32'(fc_bus), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      enable = 1'b1;
      @(negedge clk);

      run_access("rd_to",     1'b1, 1'b0, 32'h100, 0, 0, 0, 0);
      pulse_clr("irq_clear");
      run_access("wr_fc",     1'b0, 1'b1, 32'h200, 2, 0, 0, 0);
      run_access("rd_fc_lim", 1'b1, 1'b0, 32'h204, 5, 0, 0, 0);
      run_access("wr_to",     1'b0, 1'b1, 32'h300, 0, 0, 0, 0);
      run_access("rd_to2",    1'b1, 1'b0, 32'h304, 0, 0, 0, 0);
      run_access("rdwr_to",   1'b1, 1'b1, 32'h308, 0, 0, 0, 0);
      pulse_clr("irq_clear2");
      run_access("clr_race",  1'b1, 1'b0, 32'h30c, 0, 0, 0, 5);
      run_access("abort",     1'b1, 1'b0, 32'h400, 0, 4, 0, 0);
      run_access("dis_mid",   1'b1, 1'b0, 32'h404, 0, 0, 2, 0);

      // Strobe held while disabled in IDLE must never start counting.
      enable = 1'b0;
      bus.rd_bus = 1'b1;
      bus.addr_bus = 32'h408;
      saw = 1'b0;
      for (int j = 0; j < 12; j++) begin
         @(negedge clk);
         if (access_timeout) saw = 1'b1;
      end
      check("dis_idle.timeout", 32'(saw), 32'd0);
      bus.rd_bus = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      check("dis_idle.fault_count", 32'(fault_count), m_cnt);

      // Asynchronous reset while forcing completion.
      bus.rd_bus = 1'b1;
      bus.addr_bus = 32'h500;
      saw = 1'b0;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         if (access_timeout) begin
            saw = 1'b1;
            break;
         end
      end
      check("rst_mid.reached_notify", 32'(saw), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("rst_mid.access_timeout", 32'(access_timeout), 32'd0);
      check("rst_mid.fc_bus", 32'(fc_bus), 32'd0);
      check("rst_mid.irq", 32'(irq), 32'd0);
      check("rst_mid.fault_count", 32'(fault_count), 32'd0);
      check("rst_mid.fault_addr", fault_addr, 32'd0);
      check("rst_mid.fault_is_wr", 32'(fault_is_wr), 32'd0);
      bus.rd_bus = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid.after", 32'(access_timeout), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
